// File: rtl/eight_to_one_mux.sv
// 8:1 mux as a tree of 2:1 cells, with combinational y and registered y_q.
// Define EIGHT_TO_ONE_MUX_PIPE_EN to register every tree level (3-cycle y_q).
module mux2 #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             sel,
  output logic [WIDTH-1:0] out
);
  assign out = sel ? in1 : in0;
endmodule

module eight_to_one_mux #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [8*WIDTH-1:0] a,
  input  logic [2:0]         s,
  output logic [WIDTH-1:0]   y,
  output logic [WIDTH-1:0]   y_q
);
  logic [3:0][WIDTH-1:0] m0;
  logic [1:0][WIDTH-1:0] m1;

  for (genvar k = 0; k < 4; k++) begin : g_l0
    mux2 #(.WIDTH(WIDTH)) u_mux (
      .in0 (a[(2*k)*WIDTH +: WIDTH]),
      .in1 (a[(2*k+1)*WIDTH +: WIDTH]),
      .sel (s[0]),
      .out (m0[k])
    );
  end

  for (genvar j = 0; j < 2; j++) begin : g_l1
    mux2 #(.WIDTH(WIDTH)) u_mux (
      .in0 (m0[2*j]),
      .in1 (m0[2*j+1]),
      .sel (s[1]),
      .out (m1[j])
    );
  end

  mux2 #(.WIDTH(WIDTH)) u_l2 (
    .in0 (m1[0]),
    .in1 (m1[1]),
    .sel (s[2]),
    .out (y)
  );

`ifdef EIGHT_TO_ONE_MUX_PIPE_EN
  // Upper select bits travel alongside the data so each stage sees its own s.
  logic [3:0][WIDTH-1:0] m0_d, m0_q;
  logic [1:0][WIDTH-1:0] m1_d, m1_q;
  logic [1:0]            s12_d, s12_q;
  logic                  s2_d, s2_q;
  logic [WIDTH-1:0]      y_d, y_qq;
  logic [1:0][WIDTH-1:0] pm1;
  logic [WIDTH-1:0]      py;

  for (genvar j = 0; j < 2; j++) begin : g_p1
    mux2 #(.WIDTH(WIDTH)) u_mux (
      .in0 (m0_q[2*j]),
      .in1 (m0_q[2*j+1]),
      .sel (s12_q[0]),
      .out (pm1[j])
    );
  end

  mux2 #(.WIDTH(WIDTH)) u_p2 (
    .in0 (m1_q[0]),
    .in1 (m1_q[1]),
    .sel (s2_q),
    .out (py)
  );

  always_comb begin
    m0_d  = m0;
    s12_d = s[2:1];
    m1_d  = pm1;
    s2_d  = s12_q[1];
    y_d   = py;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_q  <= '0;
      s12_q <= '0;
      m1_q  <= '0;
      s2_q  <= 1'b0;
      y_qq  <= '0;
    end else begin
      m0_q  <= m0_d;
      s12_q <= s12_d;
      m1_q  <= m1_d;
      s2_q  <= s2_d;
      y_qq  <= y_d;
    end
  end

  assign y_q = y_qq;
`else
  logic [WIDTH-1:0] y_d, y_qq;

  always_comb begin
    y_d = y;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) y_qq <= '0;
    else        y_qq <= y_d;
  end

  assign y_q = y_qq;
`endif
endmodule

// File: tb/tb_eight_to_one_mux.sv
// Directed bench for eight_to_one_mux: WIDTH=1 and WIDTH=4 instances.
// Latency follows EIGHT_TO_ONE_MUX_PIPE_EN.
module tb_eight_to_one_mux;
`ifdef EIGHT_TO_ONE_MUX_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst_n;
  logic [7:0]  a1;
  logic [2:0]  s1;
  logic        y1, yq1;
  logic [31:0] a4;
  logic [2:0]  s4;
  logic [3:0]  y4, yq4;

  int total = 0;
  int bad   = 0;

  eight_to_one_mux #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .s(s1), .y(y1), .y_q(yq1)
  );

  eight_to_one_mux #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .s(s4), .y(y4), .y_q(yq4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [2:0] s;
    logic       y;
  } vec_t;

  vec_t vecs[24];

  task automatic chk(input string name, input logic [3:0] act,
                     input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  logic hist[16];

  initial begin
    for (int i = 0; i < 8; i++) begin
      vecs[i].a    = 8'b11001100;
      vecs[i].s    = 3'(i);
      vecs[i].y    = 1'((i >> 1) & 1);
      vecs[8+i].a  = 8'b10000000;
      vecs[8+i].s  = 3'(i);
      vecs[8+i].y  = (i == 7);
      vecs[16+i].a = 8'b01111111;
      vecs[16+i].s = 3'(i);
      vecs[16+i].y = (i != 7);
    end

    rst_n = 1'b0;
    a1 = 8'hFF;
    s1 = 3'd3;
    a4 = '0;
    s4 = '0;
    for (int l = 0; l < 8; l++) a4[l*4 +: 4] = 4'(l + 8);

    // y_q must stay 0 through clock edges while reset is held
    repeat (3) begin
      @(negedge clk);
      #1 chk("rst_hold_yq", {3'b0, yq1}, 4'h0);
    end
    chk("rst_y_comb", {3'b0, y1}, 4'h1);

    rst_n = 1'b1;
    for (int e = 1; e <= LAT; e++) begin
      @(negedge clk);
      #1 chk("rel_yq", {3'b0, yq1}, (e == LAT) ? 4'h1 : 4'h0);
    end

    // Async reset between edges
    #1 rst_n = 1'b0;
    #1 chk("async_rst_yq", {3'b0, yq1}, 4'h0);
    chk("async_rst_y", {3'b0, y1}, 4'h1);
    a1 = 8'h00;
    #1 chk("rst_y_track", {3'b0, y1}, 4'h0);
    @(negedge clk);
    #1 chk("rst_still_yq", {3'b0, yq1}, 4'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      a1 = vecs[i].a;
      s1 = vecs[i].s;
      #10 chk("vec_y", {3'b0, y1}, {3'b0, vecs[i].y});
    end

    // Agreeing lanes with a partly unknown select
    a1 = 8'hFF;
    s1 = 3'b1x0;
    #1 chk("x_sel_agree", {3'b0, y1}, 4'h1);
    a1 = 8'b10101010;
    s1 = 3'bxx1;
    #1 chk("x_sel_odd", {3'b0, y1}, 4'h1);

    // WIDTH=4: lane i = i+8
    @(negedge clk);
    s4 = 3'd5;
    #1 chk("w4_y", y4, 4'hD);
    repeat (LAT) @(negedge clk);
    #1 chk("w4_yq", yq4, 4'hD);
    s4 = 3'd0;
    #1 chk("w4_y0", y4, 4'h8);
    s4 = 3'd7;
    #1 chk("w4_y7", y4, 4'hF);

    // Simultaneous a/s change
    a1 = 8'b00100000;
    s1 = 3'd5;
    #1 chk("simul_change", {3'b0, y1}, 4'h1);

    // Select stepping every cycle: y_q replays y delayed by LAT
    a1 = 8'b10110010;
    for (int k = 0; k < 8 + LAT; k++) begin
      @(negedge clk);
      s1 = 3'(k);
      #1 hist[k] = y1;
      if (k < 8)
        chk("seq_y", {3'b0, y1}, {3'b0, a1[k]});
      if (k >= LAT)
        chk("seq_yq", {3'b0, yq1}, {3'b0, hist[k-LAT]});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
